mult32x32_sched: RTL and testbench
==================================

// Module: mult32x32_sched
// PURPOSE
//  Round-robin scheduler sharing one mult32x32_fast datapath (FSM + 16x16 core)
//  between NUM_REQ requesters. Accepts an operand pair per valid/ready handshake,
//  latches it, drives the multiplier's start, tracks busy and returns the 64-bit
//  product with a one-cycle response pulse. Includes a busy watchdog.
// PARAMETERS
//  NUM_REQ  2  number of requesters (>=2)
//  TIMEOUT  6  max RUN cycles with busy=1 before abort (must be >4)
// PORTS
//  clk          in   1             clock; all state on posedge
//  reset        in   1             asynchronous, active-high reset
//  req_valid    in   NUM_REQ       per-requester operand valid
//  req_a        in   NUM_REQ x 32  operand A per requester
//  req_b        in   NUM_REQ x 32  operand B per requester
//  req_ready    out  NUM_REQ       one-hot accept (IDLE only)
//  rsp_valid    out  NUM_REQ       one-hot 1-cycle result pulse to owner
//  rsp_product  out  64            registered product, held until next result
//  err          out  1             1-cycle pulse on watchdog abort
//  mult_start   out  1             to multiplier start
//  mult_a       out  32            registered operand A to multiplier
//  mult_b       out  32            registered operand B to multiplier
//  mult_busy    in   1             from multiplier busy
//  mult_product in   64            from multiplier product register
// BEHAVIOUR
//  Reset: state IDLE, rr pointer 0, owner 0, mult_a/b 0, rsp_product 0, all
//   outputs 0. Reset mid-operation abandons the op; no rsp_valid, no err.
//  States: IDLE -> ISSUE -> RUN -> DONE -> IDLE; RUN -> ABORT -> IDLE.
//  IDLE: arbiter picks first i with req_valid[i], searching from pointer upward
//   with wrap. req_ready[winner]=1 combinationally; others 0. On handshake (cycle
//   H): latch req_a/req_b into mult_a/mult_b and owner=i; pointer=(i+1)%NUM_REQ;
//   go to ISSUE. Requester holds a/b stable while valid and not ready.
//  ISSUE: mult_start=1 for exactly one cycle; go to RUN; clear watchdog count.
//  RUN: mult_busy=1 -> stay, count++. mult_busy=0 -> capture mult_product into
//   rsp_product on that edge, go to DONE. count==TIMEOUT with busy=1 -> ABORT.
//  DONE: rsp_valid[owner]=1 one cycle -> IDLE. No new accept in DONE.
//  ABORT: err=1 one cycle, rsp_product unchanged, no rsp_valid -> IDLE.
//  Latency: multiplier busy lasts k=1..4 cycles (by MSW zero-ness). rsp_valid
//   at H+3+k: H+4 (both MSW 0) to H+7 (both MSW nonzero).
//  Throughput: next accept earliest at H+4+k; one op in flight at a time.
//  req_ready stays 0 outside IDLE. req_valid dropped before handshake is legal.
//  mult_a/mult_b constant from H+1 until next handshake.
//  Pointer advances only on accept, never on abort.
//  Watchdog count width $clog2(TIMEOUT+1); saturates, no wrap.
// STRUCTURE
//  Package mult_sched_pkg: sched_state_t enum {S_IDLE,S_ISSUE,S_RUN,S_DONE,
//   S_ABORT}, localparams PROD_W=64, OPND_W=32.
//  Sub-module rr_arbiter #(N): req[N], ptr, gnt one-hot, gnt_idx (combinational).
//  Top holds FSM, pointer, operand/owner/product registers, watchdog.
// TESTING
//  1 req0 a=0x00001234 b=0x00005678 -> start at H+1, rsp_valid[0] at H+4,
//    rsp_product=0x0000000006260060.
//  2 req1 a=b=0xFFFFFFFF -> busy 4 cycles, rsp_valid[1] at H+7,
//    rsp_product=0xFFFFFFFE00000001.
//  3 both valid after reset, a0=2 b0=3, a1=5 b1=7 -> req0 first (product 6),
//    then req1 (product 35); third back-to-back req0+req1 -> req0 wins (ptr=0).
//  4 a=0x00010000 b=0x00000003 (a MSW!=0, b MSW=0) -> k=2, rsp at H+5,
//    product 0x30000.
//  5 mult_busy forced 1 -> err pulse after 6 RUN cycles, no rsp_valid,
//    req_ready returns next cycle.
//  6 reset asserted during RUN -> all outputs 0 immediately; next request
//    completes normally with correct product.

Source files
------------

// File: rtl/mult_sched_pkg.sv
// Shared types and widths for the round-robin multiplier scheduler.
package mult_sched_pkg;

  localparam int unsigned PROD_W = 64;
  localparam int unsigned OPND_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_RUN,
    S_DONE,
    S_ABORT
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr, with wrap.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);
  localparam int unsigned IDX_W = $clog2(N);

  int idx;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = 0;
    for (int off = int'(N) - 1; off >= 0; off--) begin
      idx = int'(ptr) + off;
      if (idx >= int'(N)) idx = idx - int'(N);
      if (req[IDX_W'(idx)]) begin
        gnt               = '0;
        gnt[IDX_W'(idx)]  = 1'b1;
        gnt_idx           = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mult32x32_sched.sv
// Shares one external 32x32 multiplier between NUM_REQ requesters, one op in flight.
module mult32x32_sched
  import mult_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TIMEOUT = 6
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][OPND_W-1:0]  req_a,
  input  logic [NUM_REQ-1:0][OPND_W-1:0]  req_b,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [PROD_W-1:0]               rsp_product,
  output logic                            err,
  output logic                            mult_start,
  output logic [OPND_W-1:0]               mult_a,
  output logic [OPND_W-1:0]               mult_b,
  input  logic                            mult_busy,
  input  logic [PROD_W-1:0]               mult_product
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  sched_state_t       state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [OPND_W-1:0]  mult_a_q, mult_a_d;
  logic [OPND_W-1:0]  mult_b_q, mult_b_d;
  logic [PROD_W-1:0]  rsp_product_q, rsp_product_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               start_q, start_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic               err_q, err_d;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               accept;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = (state_q == S_IDLE) ? gnt : '0;
  assign accept    = |(req_valid & req_ready);

  // Pulse outputs are set on the transition into the state that owns them.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    mult_a_d      = mult_a_q;
    mult_b_d      = mult_b_q;
    rsp_product_d = rsp_product_q;
    cnt_d         = cnt_q;
    start_d       = 1'b0;
    rsp_valid_d   = '0;
    err_d         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mult_a_d = req_a[gnt_idx];
          mult_b_d = req_b[gnt_idx];
          owner_d  = gnt_idx;
          ptr_d    = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
          start_d  = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (!mult_busy) begin
          rsp_product_d = mult_product;
          rsp_valid_d   = NUM_REQ'(1) << owner_q;
          state_d       = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE, S_ABORT: state_d = S_IDLE;
      default:         state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      owner_q       <= '0;
      mult_a_q      <= '0;
      mult_b_q      <= '0;
      rsp_product_q <= '0;
      cnt_q         <= '0;
      start_q       <= 1'b0;
      rsp_valid_q   <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      mult_a_q      <= mult_a_d;
      mult_b_q      <= mult_b_d;
      rsp_product_q <= rsp_product_d;
      cnt_q         <= cnt_d;
      start_q       <= start_d;
      rsp_valid_q   <= rsp_valid_d;
      err_q         <= err_d;
    end
  end

  assign mult_start  = start_q;
  assign mult_a      = mult_a_q;
  assign mult_b      = mult_b_q;
  assign rsp_product = rsp_product_q;
  assign rsp_valid   = rsp_valid_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mult32x32_sched.sv
// Bench for mult32x32_sched: multiplier responder, cycle model of the schedule, directed tests.
module tb_mult32x32_sched;

  localparam int NR  = 2;
  localparam int TMO = 6;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NR-1:0]        req_valid;
  logic [NR-1:0][31:0]  req_a;
  logic [NR-1:0][31:0]  req_b;
  logic [NR-1:0]        req_ready;
  logic [NR-1:0]        rsp_valid;
  logic [63:0]          rsp_product;
  logic                 err;
  logic                 mult_start;
  logic [31:0]          mult_a;
  logic [31:0]          mult_b;
  logic                 mult_busy;
  logic [63:0]          mult_product;

  mult32x32_sched #(.NUM_REQ(NR), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_product  (rsp_product),
    .err          (err),
    .mult_start   (mult_start),
    .mult_a       (mult_a),
    .mult_b       (mult_b),
    .mult_busy    (mult_busy),
    .mult_product (mult_product)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Busy cycles of the shared multiplier, set by which operand MSWs are nonzero.
  function automatic int lat_k(input logic [31:0] a, input logic [31:0] b);
    int k;
    k = 1;
    if (a[31:16] != 16'h0) k++;
    if (b[31:16] != 16'h0) k++;
    if (a[31:16] != 16'h0 && b[31:16] != 16'h0) k++;
    return k;
  endfunction

  // Multiplier responder; force_busy makes it hang busy to trip the watchdog.
  logic        force_busy = 1'b0;
  int          busy_cnt;
  logic [31:0] op_a, op_b;
  assign mult_busy = (busy_cnt != 0);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_cnt     <= 0;
      mult_product <= 64'h0;
      op_a         <= 32'h0;
      op_b         <= 32'h0;
    end else if (mult_start) begin
      op_a         <= mult_a;
      op_b         <= mult_b;
      busy_cnt     <= force_busy ? 100000 : lat_k(mult_a, mult_b);
      mult_product <= 64'hDEAD_BEEF_DEAD_BEEF;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) mult_product <= 64'(op_a) * 64'(op_b);
    end
  end

  // Schedule model and per-cycle compare, sampled on the falling edge.
  int          t = 0;
  int          m_h = -100, rsp_t = -1, err_t = -1, busy_until = 0;
  int          m_ptr = 0, m_owner = 0;
  logic [31:0] m_a = 0, m_b = 0;
  logic [63:0] m_prod = 0, pend_prod = 0;
  logic [NR-1:0] exp_ready, exp_rsp;
  int          win;

  int          obs_cnt = 0, err_cnt = 0, err_lat = 0;
  int          obs_lat   [0:31];
  logic [63:0] obs_prod  [0:31];
  logic [NR-1:0] obs_owner [0:31];

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        m_ptr = 0; m_prod = 0; m_a = 0; m_b = 0;
        m_h = -100; rsp_t = -1; err_t = -1; busy_until = 0;
        chk("rst_req_ready",   req_ready,   0);
        chk("rst_rsp_valid",   rsp_valid,   0);
        chk("rst_err",         err,         0);
        chk("rst_mult_start",  mult_start,  0);
        chk("rst_mult_a",      mult_a,      0);
        chk("rst_mult_b",      mult_b,      0);
        chk("rst_rsp_product", rsp_product, 0);
      end else begin
        if (t == rsp_t) m_prod = pend_prod;
        exp_ready = '0;
        win = -1;
        if (t >= busy_until) begin
          for (int s = 0; s < NR; s++) begin
            int i;
            i = (m_ptr + s) % NR;
            if (req_valid[i] && win < 0) win = i;
          end
          if (win >= 0) exp_ready[win] = 1'b1;
        end
        exp_rsp = '0;
        if (t == rsp_t) exp_rsp[m_owner] = 1'b1;
        chk("req_ready",   req_ready,   exp_ready);
        chk("mult_start",  mult_start,  (t == m_h + 1));
        chk("rsp_valid",   rsp_valid,   exp_rsp);
        chk("err",         err,         (t == err_t));
        chk("rsp_product", rsp_product, m_prod);
        chk("mult_a",      mult_a,      m_a);
        chk("mult_b",      mult_b,      m_b);
        if (rsp_valid != '0 && obs_cnt < 32) begin
          obs_lat[obs_cnt]   = t - m_h;
          obs_prod[obs_cnt]  = rsp_product;
          obs_owner[obs_cnt] = rsp_valid;
          obs_cnt++;
        end
        if (err) begin
          err_lat = t - m_h;
          err_cnt++;
        end
        if (win >= 0) begin
          m_h     = t;
          m_owner = win;
          m_a     = req_a[win];
          m_b     = req_b[win];
          m_ptr   = (win + 1) % NR;
          if (force_busy) begin
            rsp_t      = -1;
            err_t      = t + 3 + TMO;
            busy_until = err_t + 1;
          end else begin
            pend_prod  = 64'(m_a) * 64'(m_b);
            rsp_t      = t + 3 + lat_k(m_a, m_b);
            err_t      = -1;
            busy_until = rsp_t + 1;
          end
        end
      end
      t++;
    end
  end

  task automatic issue(input logic [NR-1:0] mask, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [31:0] a1, input logic [31:0] b1);
    logic [NR-1:0] pend;
    int n;
    pend = mask;
    n = 0;
    @(posedge clk); #1;
    req_a[0] = a0; req_b[0] = b0;
    req_a[1] = a1; req_b[1] = b1;
    req_valid = mask;
    while (pend != '0 && n < 200) begin
      @(negedge clk);
      pend = pend & ~(req_valid & req_ready);
      @(posedge clk); #1;
      req_valid = req_valid & pend;
      n++;
    end
    chk("accept_timeout", pend, 0);
  endtask

  task automatic wait_rsp(input int target);
    int n;
    n = 0;
    while (obs_cnt < target && n < 60) begin
      @(posedge clk);
      n++;
    end
    chk("rsp_timeout", (obs_cnt >= target), 1);
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // 1: both MSWs zero -> response four cycles after the handshake
    issue(2'b01, 32'h0000_1234, 32'h0000_5678, 32'h0, 32'h0);
    wait_rsp(1);
    chk("t1_lat",   obs_lat[0],   4);
    chk("t1_prod",  obs_prod[0],  64'h0000_0000_0626_0060);
    chk("t1_owner", obs_owner[0], 2'b01);

    // 2: both MSWs nonzero -> longest latency
    issue(2'b10, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_rsp(2);
    chk("t2_lat",   obs_lat[1],   7);
    chk("t2_prod",  obs_prod[1],  64'hFFFF_FFFE_0000_0001);
    chk("t2_owner", obs_owner[1], 2'b10);

    // 3: contention from reset, then a second contended round
    reset_pulse();
    issue(2'b11, 32'd2, 32'd3, 32'd5, 32'd7);
    wait_rsp(4);
    chk("t3_first_owner",  obs_owner[2], 2'b01);
    chk("t3_first_prod",   obs_prod[2],  64'd6);
    chk("t3_second_owner", obs_owner[3], 2'b10);
    chk("t3_second_prod",  obs_prod[3],  64'd35);
    issue(2'b11, 32'd2, 32'd3, 32'd5, 32'd7);
    wait_rsp(6);
    chk("t3_third_owner", obs_owner[4], 2'b01);
    chk("t3_third_prod",  obs_prod[4],  64'd6);
    chk("t3_fourth_owner", obs_owner[5], 2'b10);

    // 4: one MSW nonzero
    issue(2'b01, 32'h0001_0000, 32'h0000_0003, 32'h0, 32'h0);
    wait_rsp(7);
    chk("t4_lat",  obs_lat[6],  5);
    chk("t4_prod", obs_prod[6], 64'h0000_0000_0003_0000);

    // 5: multiplier stuck busy -> watchdog abort, product held
    force_busy = 1'b1;
    issue(2'b01, 32'd9, 32'd9, 32'h0, 32'h0);
    begin
      int n;
      n = 0;
      while (err_cnt < 1 && n < 40) begin
        @(posedge clk);
        n++;
      end
    end
    chk("t5_err_seen",  err_cnt, 1);
    chk("t5_err_lat",   err_lat, 9);
    chk("t5_no_rsp",    obs_cnt, 7);
    repeat (2) @(posedge clk);
    #1 chk("t5_prod_held", rsp_product, 64'h0000_0000_0003_0000);
    force_busy = 1'b0;
    reset_pulse();

    // 6: reset while the op is running, then a clean op
    issue(2'b10, 32'h0, 32'h0, 32'h0002_0000, 32'h0003_0000);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("t6_rsp_valid", rsp_valid,   0);
    chk("t6_err",       err,         0);
    chk("t6_start",     mult_start,  0);
    chk("t6_mult_a",    mult_a,      0);
    chk("t6_prod",      rsp_product, 0);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (8) @(posedge clk);
    chk("t6_no_rsp", obs_cnt, 7);
    issue(2'b10, 32'h0, 32'h0, 32'h0000_1234, 32'h0000_0010);
    wait_rsp(8);
    chk("t6_lat",   obs_lat[7],   4);
    chk("t6_prod",  obs_prod[7],  64'h0000_0000_0001_2340);
    chk("t6_owner", obs_owner[7], 2'b10);
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
